// File: rtl/rectangle_duty_decoder_pkg.sv
// Shared encodings for the rectangle duty decoder: duty types, window classes, FSM states.
package rectangle_pkg;

    // Duty-cycle type as produced by the rectangle sequencer
    typedef enum logic [1:0] {
        DUTY_12_5 = 2'd0,
        DUTY_25   = 2'd1,
        DUTY_50   = 2'd2,
        DUTY_75   = 2'd3
    } duty_t;

    // Length of the single cyclic run of ones for each duty type, indexed by duty_t
    localparam int RUN_LEN [4] = '{1, 2, 4, 6};

    // Classification of one 8-sample window; duty classes share the duty_t numbering
    typedef enum logic [2:0] {
        CLS_DUTY0   = 3'd0,
        CLS_DUTY1   = 3'd1,
        CLS_DUTY2   = 3'd2,
        CLS_DUTY3   = 3'd3,
        CLS_SILENT  = 3'd4,
        CLS_INVALID = 3'd5
    } class_t;

    // Lock state machine
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Window class that a given duty type is expected to produce
    function automatic class_t duty_to_class(input duty_t d);
        return class_t'({1'b0, d});
    endfunction

    // Duty type carried by a duty class (low bits of the class code)
    function automatic duty_t class_to_duty(input class_t c);
        return duty_t'(c[1:0]);
    endfunction

endpackage

// File: rtl/rectangle_duty_decoder_if.sv
// Serial input strobe/data and decoded status outputs of the duty decoder.
interface rectangle_duty_decoder_if;
    logic       iSample;
    logic       iData;
    logic [1:0] oDuty_cycle_type;
    logic       oValid;
    logic       oSilent;
    logic [2:0] oPhase;
    logic       oError;

    // Driver side: feeds the bitstream, observes the status
    modport master (
        output iSample, iData,
        input  oDuty_cycle_type, oValid, oSilent, oPhase, oError
    );

    // Decoder side
    modport slave (
        input  iSample, iData,
        output oDuty_cycle_type, oValid, oSilent, oPhase, oError
    );
endinterface

// File: rtl/rectangle_duty_decoder_classify.sv
// Combinational classifier: maps an 8-sample window to SILENT, a duty class or INVALID.
// A window is a valid duty when its ones form exactly one cyclic run of length 1/2/4/6.
module rectangle_duty_classify
    import rectangle_pkg::*;
(
    input  logic [7:0] win_i,
    output class_t     class_o
);

    // A run ends wherever a one is followed (cyclically) by a zero
    logic [7:0] run_end;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_run_end
            assign run_end[gi] = win_i[gi] & ~win_i[(gi + 1) % 8];
        end
    endgenerate

    logic [3:0] ones;
    logic [3:0] ends;

    // Count ones and run ends, then match the single-run length against the duty table
    always_comb begin
        ones    = '0;
        ends    = '0;
        class_o = CLS_INVALID;
        for (int i = 0; i < 8; i++) begin
            ones = ones + 4'(win_i[i]);
            ends = ends + 4'(run_end[i]);
        end
        if (ones == 4'd0) begin
            class_o = CLS_SILENT;
        end else if (ends == 4'd1) begin
            for (int k = 0; k < 4; k++) begin
                if (ones == 4'(RUN_LEN[k])) begin
                    class_o = class_t'(3'(k));
                end
            end
        end
    end

endmodule

// File: rtl/rectangle_duty_decoder.sv
// Duty decoder: shifts the serial pulse-channel waveform into an 8-sample window,
// locks onto a consistent duty class and reports type, phase, silence and mismatches.
module rectangle_duty_decoder
    import rectangle_pkg::*;
#(
    parameter int LOCK_PERIODS  = 2,
    parameter int UNLOCK_ERRORS = 2
) (
    input  logic                     clk,
    input  logic                     iReset,
    rectangle_duty_decoder_if.slave  bus
);

    localparam int MATCH_TARGET = LOCK_PERIODS * 8;
    localparam int MW           = $clog2(MATCH_TARGET + 1);
    localparam int EW           = $clog2(UNLOCK_ERRORS + 1);

    logic [7:0]    win_q,   win_d;
    logic [3:0]    fill_q,  fill_d;
    logic [2:0]    phase_q, phase_d;
    logic [MW-1:0] match_q, match_d;
    logic [EW-1:0] err_q,   err_d;
    duty_t         cand_q,  cand_d;
    state_t        state_q, state_d;
    duty_t         duty_q,  duty_d;
    logic          valid_q, valid_d;
    logic          silent_q, silent_d;
    logic          error_q, error_d;

    // Window as it will look after this sample, and whether it is then full
    logic [7:0] win_next;
    logic       full_next;
    class_t     cls;
    logic       cls_is_cand;

    assign win_next    = {win_q[6:0], bus.iData};
    assign full_next   = (fill_q >= 4'd7);
    assign cls_is_cand = (cls == duty_to_class(cand_q));

    rectangle_duty_classify u_classify (
        .win_i   (win_next),
        .class_o (cls)
    );

    // Window shift register and saturating fill count advance on every strobe
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (bus.iSample) begin
            win_d  = win_next;
            fill_d = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (iReset) begin
            win_q    <= '0;
            fill_q   <= '0;
            phase_q  <= '0;
            duty_q   <= DUTY_12_5;
            valid_q  <= 1'b0;
            silent_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            win_q    <= win_d;
            fill_q   <= fill_d;
            phase_q  <= phase_d;
            duty_q   <= duty_d;
            valid_q  <= valid_d;
            silent_q <= silent_d;
            error_q  <= error_d;
        end
    end

    // FSM state register with its candidate and counters
    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q <= HUNT;
            cand_q  <= DUTY_12_5;
            match_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    // FSM next state: only a strobe that completes a full window moves it
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        match_d = match_q;
        err_d   = err_q;
        if (bus.iSample && full_next) begin
            unique case (state_q)
                HUNT: begin
                    if (cls <= CLS_DUTY3) begin
                        state_d = CHECK;
                        cand_d  = class_to_duty(cls);
                        match_d = MW'(1);
                    end
                end
                CHECK: begin
                    if (cls_is_cand) begin
                        match_d = (match_q == MW'(MATCH_TARGET)) ? match_q : match_q + MW'(1);
                        if (match_q >= MW'(MATCH_TARGET - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (cls_is_cand) begin
                        err_d = '0;
                    end else if (cls == CLS_SILENT) begin
                        // Channel went quiet: drop lock without flagging an error
                        state_d = HUNT;
                        err_d   = '0;
                    end else if (err_q >= EW'(UNLOCK_ERRORS - 1)) begin
                        state_d = HUNT;
                        err_d   = '0;
                    end else begin
                        err_d = err_q + EW'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output next values; everything holds between strobes except the error pulse
    always_comb begin
        phase_d  = phase_q;
        duty_d   = duty_q;
        valid_d  = valid_q;
        silent_d = silent_q;
        error_d  = 1'b0;
        if (bus.iSample) begin
            phase_d  = (!win_q[0] && bus.iData) ? 3'd0 : phase_q + 3'd1;
            silent_d = full_next && (win_next == 8'd0);
            valid_d  = (state_d == LOCKED);
            if (state_q == CHECK && state_d == LOCKED) begin
                duty_d = cand_q;
            end
            error_d  = full_next && (state_q == LOCKED) && !cls_is_cand && (cls != CLS_SILENT);
        end
    end

    assign bus.oDuty_cycle_type = duty_q;
    assign bus.oValid           = valid_q;
    assign bus.oSilent          = silent_q;
    assign bus.oPhase           = phase_q;
    assign bus.oError           = error_q;

endmodule
